// File: rtl/qs_deq.sv
// Quicksort engine dequeue controller: polls banks round-robin, claims a sorted bank,
// streams its entries through a small credit-limited output FIFO and releases the bank.

package qs_pkg;
    localparam int BANKS_N = 2;
    localparam int N       = 16;
    localparam int W       = 32;

    typedef logic [$clog2(BANKS_N)-1:0] bank_id_t;
    typedef logic [$clog2(N)-1:0]       addr_t;
    typedef logic [$clog2(N+1)-1:0]     n_t;

    typedef enum logic [2:0] {
        BANK_IDLE      = 3'd0,
        BANK_LOADING   = 3'd1,
        BANK_SORTING   = 3'd2,
        BANK_SORTED    = 3'd3,
        BANK_UNLOADING = 3'd4
    } bank_status_t;

    typedef struct packed {
        bank_status_t status;
        n_t           n;
    } bank_state_t;
endpackage

// Handshake: a word moves from this block to the consumer on every rising clk edge where
// out_vld_r & out_rdy; out_vld_r/out_dat_r/out_last_r are held stable until that transfer.
module qs_deq #(
    parameter int BANKS_N = qs_pkg::BANKS_N,
    parameter int N       = qs_pkg::N,
    parameter int W       = qs_pkg::W,
    parameter int FIFO_N  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output qs_pkg::bank_id_t     deq_bank_idx_r,
    input  qs_pkg::bank_state_t  deq_bank_out,
    output logic                 deq_bank_in_vld,
    output qs_pkg::bank_state_t  deq_bank_in,
    output logic                 deq_rd_en_r,
    output qs_pkg::addr_t        deq_rd_addr_r,
    input  logic                 deq_rd_data_vld_r,
    input  logic [W-1:0]         deq_rd_data_r,
    output logic                 out_vld_r,
    output logic [W-1:0]         out_dat_r,
    output logic                 out_last_r,
    input  logic                 out_rdy,
    output logic                 busy_r
);

    localparam int FA = (FIFO_N > 1) ? $clog2(FIFO_N) : 1;
    localparam int CW = $clog2(FIFO_N + 1);
    localparam int OW = CW + 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLAIM   = 3'd1,
        S_READ    = 3'd2,
        S_DRAIN   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    qs_pkg::n_t     n_r;
    qs_pkg::n_t     ret_cnt;
    qs_pkg::addr_t  ptr;
    logic [1:0]     inflight;

    logic [W:0]     mem [FIFO_N];
    logic [FA-1:0]  wr_idx;
    logic [FA-1:0]  rd_idx;
    logic [CW-1:0]  fifo_cnt;

    logic           push;
    logic           pop;
    logic [OW-1:0]  outstanding;
    logic           credit_ok;
    logic           issue;
    logic           last_issue;
    logic           bank_sorted;

    assign push        = deq_rd_data_vld_r;
    assign pop         = out_vld_r & out_rdy;
    assign bank_sorted = (deq_bank_out.status == qs_pkg::BANK_SORTED);

    // A request already registered on deq_rd_en_r is not yet in inflight, so it is counted
    // here; a pop this cycle frees a slot so the pipeline keeps full rate.
    assign outstanding = OW'(fifo_cnt) + OW'(inflight) + OW'(deq_rd_en_r);
    assign credit_ok   = outstanding < (OW'(FIFO_N) + OW'(pop));
    assign issue       = (state == S_READ) && credit_ok;
    assign last_issue  = issue && (qs_pkg::n_t'(ptr) == n_r - 1'b1);

    assign out_vld_r  = (fifo_cnt != '0);
    assign out_dat_r  = mem[rd_idx][W:1];
    assign out_last_r = mem[rd_idx][0];

    function automatic logic [FA-1:0] fifo_inc(input logic [FA-1:0] i);
        return (i == FA'(FIFO_N - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic qs_pkg::bank_id_t bank_inc(input qs_pkg::bank_id_t b);
        return (b == qs_pkg::bank_id_t'(BANKS_N - 1)) ? '0 : b + 1'b1;
    endfunction

    always_comb begin
        state_nxt       = state;
        deq_bank_in_vld = 1'b0;
        deq_bank_in     = '{status: qs_pkg::BANK_IDLE, n: '0};
        case (state)
            S_IDLE: begin
                if (bank_sorted) state_nxt = S_CLAIM;
            end
            S_CLAIM: begin
                deq_bank_in_vld = 1'b1;
                deq_bank_in     = '{status: qs_pkg::BANK_UNLOADING, n: n_r};
                state_nxt       = (n_r == '0) ? S_RELEASE : S_READ;
            end
            S_READ: begin
                if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (ret_cnt == n_r) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                deq_bank_in_vld = 1'b1;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            busy_r         <= 1'b0;
            deq_bank_idx_r <= '0;
            n_r            <= '0;
            ret_cnt        <= '0;
            ptr            <= '0;
            inflight       <= '0;
            deq_rd_en_r    <= 1'b0;
            deq_rd_addr_r  <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            fifo_cnt       <= '0;
            for (int i = 0; i < FIFO_N; i++) mem[i] <= '0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt != S_IDLE);

            if (((state == S_IDLE) && !bank_sorted) || (state == S_RELEASE))
                deq_bank_idx_r <= bank_inc(deq_bank_idx_r);
            if ((state == S_IDLE) && bank_sorted)
                n_r <= deq_bank_out.n;

            deq_rd_en_r <= issue;
            if (issue) begin
                deq_rd_addr_r <= ptr;
                ptr           <= ptr + 1'b1;
            end

            case ({deq_rd_en_r, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            // Last flag is decided on the return side so it follows the data, not the request.
            if (push) begin
                mem[wr_idx] <= {deq_rd_data_r, (ret_cnt == n_r - 1'b1)};
                wr_idx      <= fifo_inc(wr_idx);
                ret_cnt     <= ret_cnt + 1'b1;
            end
            if (pop) rd_idx <= fifo_inc(rd_idx);

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (state == S_CLAIM) begin
                ptr     <= '0;
                ret_cnt <= '0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt == CW'(FIFO_N))));
    a_no_orphan_data: assert property (@(posedge clk) disable iff (rst)
        !(push && (inflight == 2'd0)));
    a_inflight_max: assert property (@(posedge clk) disable iff (rst)
        inflight <= 2'd2);

endmodule

// File: tb/tb_qs_deq.sv
// Directed bench for qs_deq: a two-bank array model with a 2-cycle read pipe, a word
// scoreboard, bank-write and read-address logs, and hand-computed expectations.
module tb_qs_deq;

    localparam int W      = 32;
    localparam int N      = 16;
    localparam int FIFO_N = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    qs_pkg::bank_id_t    deq_bank_idx_r;
    qs_pkg::bank_state_t deq_bank_out;
    logic                deq_bank_in_vld;
    qs_pkg::bank_state_t deq_bank_in;
    logic                deq_rd_en_r;
    qs_pkg::addr_t       deq_rd_addr_r;
    logic                deq_rd_data_vld_r = 1'b0;
    logic [W-1:0]        deq_rd_data_r = '0;
    logic                out_vld_r;
    logic [W-1:0]        out_dat_r;
    logic                out_last_r;
    logic                out_rdy = 1'b1;
    logic                busy_r;

    qs_deq #(.BANKS_N(2), .N(N), .W(W), .FIFO_N(FIFO_N)) dut (
        .clk               (clk),
        .rst               (rst),
        .deq_bank_idx_r    (deq_bank_idx_r),
        .deq_bank_out      (deq_bank_out),
        .deq_bank_in_vld   (deq_bank_in_vld),
        .deq_bank_in       (deq_bank_in),
        .deq_rd_en_r       (deq_rd_en_r),
        .deq_rd_addr_r     (deq_rd_addr_r),
        .deq_rd_data_vld_r (deq_rd_data_vld_r),
        .deq_rd_data_r     (deq_rd_data_r),
        .out_vld_r         (out_vld_r),
        .out_dat_r         (out_dat_r),
        .out_last_r        (out_last_r),
        .out_rdy           (out_rdy),
        .busy_r            (busy_r)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bank array model ----------------
    qs_pkg::bank_status_t st [2];
    qs_pkg::n_t           bn [2];
    logic [W-1:0]         bank_mem [2][N];
    logic [1:0]           set_mask = 2'b00;
    qs_pkg::n_t           set_n [2];
    logic                 rd_p1 = 1'b0;
    logic [W-1:0]         dat_p1 = '0;
    int                   cyc = 0;

    assign deq_bank_out = '{status: st[deq_bank_idx_r], n: bn[deq_bank_idx_r]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < 2; b++) begin
            if (set_mask[b]) begin
                st[b] <= qs_pkg::BANK_SORTED;
                bn[b] <= set_n[b];
            end else if (rst) begin
                st[b] <= qs_pkg::BANK_IDLE;
                bn[b] <= '0;
            end else if (deq_bank_in_vld && (deq_bank_idx_r == b[0])) begin
                st[b] <= deq_bank_in.status;
                bn[b] <= deq_bank_in.n;
            end
        end
        rd_p1             <= deq_rd_en_r && !rst;
        dat_p1            <= bank_mem[deq_bank_idx_r][deq_rd_addr_r];
        deq_rd_data_vld_r <= rd_p1 && !rst;
        deq_rd_data_r     <= dat_p1;
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [W:0]  exp_q [$];
    logic [8:0]  wr_log [$];
    logic [3:0]  addr_log [$];
    int          pop_cyc [$];
    int          issued, returned, popped, max_infl, max_outst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mk_wr(input logic b, input qs_pkg::bank_status_t s,
                                         input logic [4:0] n);
        return {b, 3'(s), n};
    endfunction

    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (issued - returned > max_infl) max_infl = issued - returned;
                if (issued + int'(deq_rd_en_r) - popped > max_outst)
                    max_outst = issued + int'(deq_rd_en_r) - popped;
                if (deq_rd_en_r) begin
                    issued++;
                    addr_log.push_back(deq_rd_addr_r);
                end
                if (deq_rd_data_vld_r) returned++;
                if (deq_bank_in_vld)
                    wr_log.push_back({deq_bank_idx_r, 3'(deq_bank_in.status), deq_bank_in.n});
                if (out_vld_r && out_rdy) begin
                    check("word_avail", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_word", {out_dat_r, out_last_r}, e);
                    end
                    pop_cyc.push_back(cyc);
                    popped++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_test(input logic [1:0] mask, input int n0, input int n1);
        rst      = 1'b1;
        set_mask = mask;
        set_n[0] = qs_pkg::n_t'(n0);
        set_n[1] = qs_pkg::n_t'(n1);
        @(posedge clk); #1;
        rst      = 1'b0;
        set_mask = 2'b00;
        exp_q.delete(); wr_log.delete(); addr_log.delete(); pop_cyc.delete();
        issued = 0; returned = 0; popped = 0; max_infl = 0; max_outst = 0;
    endtask

    task automatic expect_word(input logic [W-1:0] d, input logic last);
        exp_q.push_back({d, last});
    endtask

    task automatic wait_done(input int budget, input bit toggle, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (toggle) out_rdy = ~out_rdy;
            if (i >= 8 && !busy_r && !out_vld_r && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (toggle) out_rdy = 1'b1;
        check({tag, "_done"}, 64'(done), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] t1_dat [4];
        logic [W-1:0] t4_dat [5];
        logic [8:0]   t4_wr [4];
        logic [3:0]   t4_addr [5];
        t1_dat  = '{32'd3, 32'd5, 32'd9, 32'd12};
        t4_dat  = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
        t4_addr = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2};
        t4_wr   = '{mk_wr(1'b0, qs_pkg::BANK_UNLOADING, 5'd2), mk_wr(1'b0, qs_pkg::BANK_IDLE, 5'd0),
                    mk_wr(1'b1, qs_pkg::BANK_UNLOADING, 5'd3), mk_wr(1'b1, qs_pkg::BANK_IDLE, 5'd0)};

        // reset values
        start_test(2'b00, 0, 0);
        check("rst_busy", 64'(busy_r), 0);
        check("rst_vld", 64'(out_vld_r), 0);
        check("rst_idx", 64'(deq_bank_idx_r), 0);
        check("rst_rd_en", 64'(deq_rd_en_r), 0);
        check("rst_addr", 64'(deq_rd_addr_r), 0);
        check("rst_dat", 64'(out_dat_r), 0);
        check("rst_last", 64'(out_last_r), 0);

        // bank 0, n=4, consumer always ready
        for (int i = 0; i < 4; i++) bank_mem[0][i] = t1_dat[i];
        out_rdy = 1'b1;
        start_test(2'b01, 4, 0);
        for (int i = 0; i < 4; i++) expect_word(t1_dat[i], i == 3);
        wait_done(60, 1'b0, "t1");
        check("t1_reads", 64'(issued), 4);
        check("t1_wr_cnt", 64'(wr_log.size()), 2);
        check("t1_wr_claim", 64'(wr_log[0]), 64'(mk_wr(1'b0, qs_pkg::BANK_UNLOADING, 5'd4)));
        check("t1_wr_release", 64'(wr_log[1]), 64'(mk_wr(1'b0, qs_pkg::BANK_IDLE, 5'd0)));
        for (int i = 1; i < 4; i++) check("t1_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 1);

        // bank 0, n=16, consumer toggling every cycle
        for (int i = 0; i < N; i++) bank_mem[0][i] = 32'h1000 + 32'(i * 3);
        start_test(2'b01, 16, 0);
        for (int i = 0; i < N; i++) expect_word(32'h1000 + 32'(i * 3), i == N - 1);
        wait_done(200, 1'b1, "t2");
        check("t2_reads", 64'(issued), 16);
        check("t2_words", 64'(popped), 16);
        check("t2_outst_le4", 64'(max_outst <= FIFO_N), 1);
        check("t2_infl_le2", 64'(max_infl <= 2), 1);
        check("t2_last_addr", 64'(addr_log[15]), 15);

        // bank 1 with n=0
        start_test(2'b10, 0, 0);
        wait_done(40, 1'b0, "t3");
        check("t3_reads", 64'(issued), 0);
        check("t3_words", 64'(popped), 0);
        check("t3_wr_claim", 64'(wr_log[0]), 64'(mk_wr(1'b1, qs_pkg::BANK_UNLOADING, 5'd0)));
        check("t3_wr_release", 64'(wr_log[1]), 64'(mk_wr(1'b1, qs_pkg::BANK_IDLE, 5'd0)));

        // both banks sorted, n=2 then n=3
        bank_mem[0][0] = t4_dat[0]; bank_mem[0][1] = t4_dat[1];
        for (int i = 0; i < 3; i++) bank_mem[1][i] = t4_dat[2+i];
        start_test(2'b11, 2, 3);
        for (int i = 0; i < 5; i++) expect_word(t4_dat[i], i == 1 || i == 4);
        wait_done(80, 1'b0, "t4");
        check("t4_wr_cnt", 64'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) check("t4_wr", 64'(wr_log[i]), 64'(t4_wr[i]));
        for (int i = 0; i < 5; i++) check("t4_addr", 64'(addr_log[i]), 64'(t4_addr[i]));

        // consumer stalled with n=8: credit limit, then release
        for (int i = 0; i < 8; i++) bank_mem[0][i] = 32'h50 + 32'(i);
        out_rdy = 1'b0;
        start_test(2'b01, 8, 0);
        for (int i = 0; i < 8; i++) expect_word(32'h50 + 32'(i), i == 7);
        repeat (30) begin @(posedge clk); #1; end
        check("t5_stall_reads", 64'(issued), 4);
        check("t5_stall_vld", 64'(out_vld_r), 1);
        check("t5_stall_words", 64'(popped), 0);
        out_rdy = 1'b1;
        wait_done(80, 1'b0, "t5");
        check("t5_reads", 64'(issued), 8);
        check("t5_words", 64'(popped), 8);

        // reset in the middle of an unload
        for (int i = 0; i < 8; i++) bank_mem[0][i] = 32'h70 + 32'(i);
        start_test(2'b01, 8, 0);
        for (int i = 0; i < 8; i++) expect_word(32'h70 + 32'(i), i == 7);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (popped >= 2) break;
        end
        check("t6_two_words", 64'(popped), 2);
        check("t6_busy", 64'(busy_r), 1);
        check("t6_mid_read", 64'(issued < 8), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_busy_rst", 64'(busy_r), 0);
        check("t6_vld_rst", 64'(out_vld_r), 0);
        check("t6_idx_rst", 64'(deq_bank_idx_r), 0);
        check("t6_rd_en_rst", 64'(deq_rd_en_r), 0);
        check("t6_addr_rst", 64'(deq_rd_addr_r), 0);
        check("t6_dat_rst", 64'(out_dat_r), 0);
        check("t6_last_rst", 64'(out_last_r), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (10) begin @(posedge clk); #1; end
        check("t6_quiet_words", 64'(popped), 2);
        check("t6_quiet_busy", 64'(busy_r), 0);

        check("final_q_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
